// File: rtl/odczyt_bitu_seq.sv
// Bit-position reader: finds the first set bit of an operand, scanning from the MSB, one bit per cycle.
// Latency: o_valid rises k edges after the accepting edge (k = found index), or BITS edges for a zero operand.
// Backpressure: the result is held in DONE until i_ready retires it; i_start is ignored outside IDLE.
//
// Index convention matches the bit-set operation: index k (1..BITS) names bit [BITS-k], so k=1 is the MSB.
// Ports:
//   i_clk, i_rst_n        rising-edge clock, asynchronous active-low reset
//   i_start, i_arg_A      request and operand, sampled together on the accepting edge in IDLE
//   i_ready               consumer ready; retires the result while o_valid is high
//   o_busy, o_valid       busy in SCAN/DONE, valid in DONE
//   o_result, o_error     found index (0 on error), zero-operand flag
//   o_remainder           only with FIND_CLEAR_EN: the operand with the found bit cleared
// Optional feature macro: FIND_CLEAR_EN.
module odczyt_bitu_seq #(
    parameter int BITS = 32,
    localparam int IDX_W = $clog2(BITS + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [BITS-1:0]  i_arg_A,
    input  logic             i_ready,
    output logic             o_busy,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_result,
    output logic             o_error
`ifdef FIND_CLEAR_EN
    ,
    output logic [BITS-1:0]  o_remainder
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] K_FIRST = IDX_W'(1);
    localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(BITS);
    localparam logic [BITS-1:0]  MSB_ONE = {1'b1, {(BITS-1){1'b0}}};

    state_t            state_q, state_d;
    logic [BITS-1:0]   shadow_q, shadow_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic [IDX_W-1:0]  result_q, result_d;
    logic              error_q, error_d;
`ifdef FIND_CLEAR_EN
    logic [BITS-1:0]   rem_q, rem_d;
`endif

    // One-hot select of bit [BITS-k]: shifting the MSB right by k-1 avoids
    // an index expression whose width differs from the bit-select range.
    logic [BITS-1:0]   sel_mask;
    logic              hit;

    assign sel_mask = MSB_ONE >> (k_q - K_FIRST);
    assign hit      = |(shadow_q & sel_mask);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            k_q      <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
`ifdef FIND_CLEAR_EN
            rem_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            k_q      <= k_d;
            result_q <= result_d;
            error_q  <= error_d;
`ifdef FIND_CLEAR_EN
            rem_q    <= rem_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        k_d      = k_q;
        result_d = result_q;
        error_d  = error_q;
`ifdef FIND_CLEAR_EN
        rem_d    = rem_q;
`endif
        case (state_q)
            IDLE: begin
                // Previous result stays visible in IDLE until a new request is accepted.
                if (i_start) begin
                    shadow_d = i_arg_A;
                    k_d      = K_FIRST;
                    result_d = '0;
                    error_d  = 1'b0;
`ifdef FIND_CLEAR_EN
                    rem_d    = '0;
`endif
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    result_d = k_q;
                    error_d  = 1'b0;
`ifdef FIND_CLEAR_EN
                    rem_d    = shadow_q & ~sel_mask;
`endif
                    state_d  = DONE;
                end else if (k_q == K_LAST) begin
                    // Terminal compare stops the counter before it could wrap.
                    result_d = '0;
                    error_d  = 1'b1;
`ifdef FIND_CLEAR_EN
                    rem_d    = shadow_q;
`endif
                    state_d  = DONE;
                end else begin
                    k_d = k_q + K_FIRST;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_busy   = (state_q != IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_result = result_q;
    assign o_error  = error_q;
`ifdef FIND_CLEAR_EN
    assign o_remainder = rem_q;
`endif

endmodule

// File: tb/tb_odczyt_bitu_seq.sv
// Bench for odczyt_bitu_seq: scoreboard of expected results, checked when o_valid rises and while held.
// Latency is measured in clock edges from the accepting edge.
// Consumer readiness is driven per operation to exercise result hold under backpressure.
module tb_odczyt_bitu_seq;

    localparam int BITS  = 32;
    localparam int IDX_W = 6;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_start;
    logic [BITS-1:0]  i_arg_A;
    logic             i_ready;
    logic             o_busy;
    logic             o_valid;
    logic [IDX_W-1:0] o_result;
    logic             o_error;
`ifdef FIND_CLEAR_EN
    logic [BITS-1:0]  o_remainder;
`endif

    odczyt_bitu_seq #(.BITS(BITS)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (i_start),
        .i_arg_A  (i_arg_A),
        .i_ready  (i_ready),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_result (o_result),
        .o_error  (o_error)
`ifdef FIND_CLEAR_EN
        ,
        .o_remainder (o_remainder)
`endif
    );

    typedef struct {
        int          k;
        int          err;
        logic [31:0] rem;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   n_results  = 0;
    bit   valid_seen = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: first set bit scanning down from the MSB, as index k with bit [BITS-k].
    function automatic void model(input logic [31:0] a, output int k, output int err,
                                  output logic [31:0] rem);
        k   = 0;
        err = 1;
        rem = a;
        for (int b = BITS - 1; b >= 0; b--) begin
            if (a[b]) begin
                k      = BITS - b;
                err    = 0;
                rem[b] = 1'b0;
                break;
            end
        end
    endfunction

    // Output monitor: pop on the rising o_valid, then require a stable result while held.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_valid && !valid_seen) begin
                valid_seen = 1;
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    n_results++;
                    chk("latency", cyc - cur.acc, cur.k == 0 ? BITS : cur.k);
                    chk("result", o_result, cur.k);
                    chk("error", o_error, cur.err);
`ifdef FIND_CLEAR_EN
                    chk("remainder", o_remainder, cur.rem);
`endif
                end
            end else if (o_valid) begin
                chk("hold_result", o_result, cur.k);
                chk("hold_error", o_error, cur.err);
            end
            if (!o_valid) valid_seen = 0;
        end else begin
            valid_seen = 0;
        end
    end

    // One complete request: accept, optional stray starts, wait for result, retire.
    task automatic run_op(input logic [31:0] a, input int ready_delay, input bit stray);
        exp_t e;
        int   t;
        @(negedge i_clk);
        i_start = 1'b1;
        i_arg_A = a;
        @(negedge i_clk);
        model(a, e.k, e.err, e.rem);
        e.acc = cyc;
        sb.push_back(e);
        // A stray start keeps i_start high across the first SCAN edge.
        i_start = stray;
        i_arg_A = $urandom;
        chk("busy_scan", o_busy, 1);
        t = 0;
        while (!o_valid && t < 100) begin
            @(negedge i_clk);
            i_start = 1'b0;
            t++;
        end
        i_start = 1'b0;
        if (!o_valid) begin
            chk("valid_timeout", 0, 1);
            return;
        end
        for (int d = 0; d < ready_delay; d++) begin
            i_start = stray && (d == 0);
            @(negedge i_clk);
        end
        i_ready = 1'b1;
        i_start = stray;
        @(negedge i_clk);
        i_ready = 1'b0;
        i_start = 1'b0;
        chk("idle_valid", o_valid, 0);
        chk("idle_busy", o_busy, 0);
        chk("idle_hold_result", o_result, e.k);
    endtask

    initial begin
        int n_before;
        logic [31:0] a;
        i_rst_n = 1'b1;
        i_start = 1'b0;
        i_arg_A = '0;
        i_ready = 1'b0;
        #1 i_rst_n = 1'b0;
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_result", o_result, 0);
        chk("rst_error", o_error, 0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;

        run_op(32'h8000_0000, 0, 0);
        run_op(32'h0000_0001, 0, 0);
        run_op(32'h0001_0000, 2, 0);
        run_op(32'h0000_0000, 1, 0);

        n_before = n_results;
        run_op(32'h4000_0000, 5, 1);
        chk("one_result", n_results - n_before, 1);

        for (int r = 0; r < 6; r++) begin
            a = $urandom >> $urandom_range(0, 31);
            run_op(a, $urandom_range(0, 3), r[0]);
        end

        // Asynchronous reset in the middle of a scan aborts the request.
        @(negedge i_clk);
        i_start = 1'b1;
        i_arg_A = 32'h0000_0004;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (9) @(negedge i_clk);
        chk("abort_busy_before", o_busy, 1);
        n_before = n_results;
        @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("abort_busy", o_busy, 0);
        chk("abort_valid", o_valid, 0);
        chk("abort_result", o_result, 0);
        chk("abort_error", o_error, 0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (40) @(negedge i_clk);
        chk("abort_no_result", n_results - n_before, 0);
        chk("abort_idle", o_busy, 0);

`ifdef FIND_CLEAR_EN
        run_op(32'h0003_0000, 0, 0);
        run_op(32'h0001_0000, 0, 0);
`endif
        run_op(32'h0000_8000, 0, 0);

        repeat (2) @(negedge i_clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
